// File: rtl/fma_wb.sv
// Writeback buffer and sticky exception accrual behind the two-cycle fmas pipe.
// Latency: issue to wb_valid is 3 cycles minimum; one op per cycle sustained.
// Backpressure: credit-gated issue_ready covers FIFO entries plus in-flight ops.
module fma_wb #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic [31:0]      fmas_rslt,
    input  logic [4:0]       fmas_flag,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic [4:0]       wb_flag,
    input  logic             fflags_clr,
    output logic [4:0]       fflags,
    output logic             ovf_err
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic [4:0]       flag;
    } wb_ent_t;

    logic             a_vld, b_vld;
    logic [TAG_W-1:0] a_tag, b_tag;

    wb_ent_t          mem [DEPTH];
    wb_ent_t          head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    logic             push, pop, full;
    logic [AW+1:0]    credit_sum;

    assign push     = b_vld;
    assign wb_valid = (count != '0);
    assign pop      = wb_valid & wb_ready;
    assign full     = (count == (AW+1)'(DEPTH));

    // Everything already committed (buffered or still in the fmas pipe) minus the slot freed now.
    assign credit_sum  = {1'b0, count} + (AW+2)'(a_vld) + (AW+2)'(b_vld) - (AW+2)'(pop);
    assign issue_ready = (credit_sum < (AW+2)'(DEPTH));

    assign head    = mem[rd_ptr];
    assign wb_tag  = head.tag;
    assign wb_data = head.data;
    assign wb_flag = head.flag;

    always_ff @(posedge clk) begin
        a_tag <= issue_tag;
        b_tag <= a_tag;
        if (push) begin
            mem[wr_ptr] <= '{tag: b_tag, data: fmas_rslt, flag: fmas_flag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld   <= 1'b0;
            b_vld   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            fflags  <= '0;
            ovf_err <= 1'b0;
        end else begin
            a_vld <= issue_valid;
            b_vld <= a_vld;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A push into a full buffer without a pop drops the oldest entry so pointers stay aligned.
            if (pop || (push && full)) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop && !full) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            fflags <= (fflags_clr ? 5'b0 : fflags) | (pop ? wb_flag : 5'b0);

            if (issue_valid && !issue_ready) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fma_wb.sv
// Bench for fma_wb: a small fmas stand-in drives results two cycles after issue,
// and a queue of outstanding ops predicts every output.
module tb_fma_wb;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             issue_valid = 1'b0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic             issue_ready;
    logic [31:0]      fmas_rslt;
    logic [4:0]       fmas_flag;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic [4:0]       wb_flag;
    logic             fflags_clr = 1'b0;
    logic [4:0]       fflags;
    logic             ovf_err;

    always #5 clk = ~clk;

    fma_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .fmas_rslt(fmas_rslt), .fmas_flag(fmas_flag),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_tag(wb_tag), .wb_data(wb_data), .wb_flag(wb_flag),
        .fflags_clr(fflags_clr), .fflags(fflags), .ovf_err(ovf_err)
    );

    // fmas stand-in: result of the op issued in T appears combinationally in T+2.
    logic [31:0] in_rslt = '0;
    logic [4:0]  in_flag = '0;
    logic        s1v, s2v;
    logic [31:0] s1r, s2r;
    logic [4:0]  s1f, s2f;

    always @(posedge clk) begin
        if (reset) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
        end else begin
            s1v <= issue_valid; s1r <= in_rslt; s1f <= in_flag;
            s2v <= s1v;         s2r <= s1r;     s2f <= s1f;
        end
    end
    assign fmas_rslt = s2v ? s2r : 32'hdeadbeef;
    assign fmas_flag = s2v ? s2f : 5'h1f;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic [4:0]       flag;
        int               rdy;
    } op_t;

    op_t        q[$];
    logic [4:0] m_fflags = '0;
    logic       m_ovf = 1'b0;
    bit         corrupt = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_iss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model, cross the edge.
    // With gate set, the issue is only made if the DUT grants it.
    task automatic step(input logic iv, input logic gate, input logic [TAG_W-1:0] tg,
                        input logic [31:0] d, input logic [4:0] f,
                        input logic wr, input logic clr, input logic rst);
        bit exp_v, exp_rdy, do_iss;
        @(negedge clk);
        wb_ready = wr; fflags_clr = clr; reset = rst;
        issue_tag = tg; in_rslt = d; in_flag = f;
        #1;
        do_iss = iv && (!gate || issue_ready === 1'b1);
        issue_valid = do_iss;
        #1;
        exp_v   = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_rdy = (q.size() - int'(exp_v && wr)) < DEPTH;
        chk("wb_valid", 32'(wb_valid), 32'(exp_v));
        chk("issue_ready", 32'(issue_ready), 32'(exp_rdy));
        chk("fflags", 32'(fflags), 32'(m_fflags));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        if (exp_v && !corrupt) begin
            chk("wb_tag", 32'(wb_tag), 32'(q[0].tag));
            chk("wb_data", wb_data, q[0].data);
            chk("wb_flag", 32'(wb_flag), 32'(q[0].flag));
        end
        if (rst) begin
            q.delete();
            m_fflags = '0;
            m_ovf    = 1'b0;
            corrupt  = 1'b0;
        end else begin
            if (clr) m_fflags = '0;
            if (exp_v && wr) begin
                m_fflags = m_fflags | q[0].flag;
                void'(q.pop_front());
            end
            if (do_iss) begin
                n_iss++;
                if (!exp_rdy) begin
                    m_ovf   = 1'b1;
                    corrupt = 1'b1;
                end
                q.push_back('{tag: tg, data: d, flag: f, rdy: cyc + 3});
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic wr);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, wr, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset state, then a single op: 1*2+1 = 3.0.
        step(1, 0, 5'd7, 32'h40400000, 5'h00, 1, 0, 0);
        idle(5, 1);

        // Signalling NaN: quiet result, NV flag accrues after the pop.
        step(1, 0, 5'd3, 32'h7fc00001, 5'h10, 1, 0, 0);
        idle(5, 1);

        // Clear coinciding with a pop of flags 0x05: popped flags survive.
        step(1, 0, 5'd9, 32'h3f800000, 5'h05, 0, 0, 0);
        idle(2, 0);
        step(0, 0, '0, '0, '0, 1, 1, 0);
        idle(2, 1);

        // Backpressure: exactly DEPTH issues granted while wb_ready is low.
        n_iss = 0;
        for (int i = 1; i <= 8; i++) step(1, 1, TAG_W'(i), 32'h1000 + 32'(i), 5'(i), 0, 0, 0);
        chk("bp_issue_count", 32'(n_iss), 32'(DEPTH));
        idle(6, 1);

        // Sustained traffic across pointer wrap, starting from a full buffer.
        for (int i = 0; i < 6; i++) step(1, 1, TAG_W'(16 + i), 32'h2000 + 32'(i), 5'h00, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(1, 1, TAG_W'(20 + i), 32'h3000 + 32'(i), 5'(i & 3), 1, 0, 0);
        idle(6, 1);

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            step(logic'($urandom_range(0, 1)), 1, TAG_W'($urandom), $urandom, 5'($urandom),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0), 0);
        end
        idle(8, 1);

        // Overflow: forced issue with no credit sets a sticky error that a flag clear ignores.
        for (int i = 0; i < 6; i++) step(1, 1, TAG_W'(i), $urandom, 5'h00, 0, 0, 0);
        step(1, 0, 5'd30, 32'h55555555, 5'h00, 0, 0, 0);
        idle(3, 0);
        step(0, 0, '0, '0, '0, 0, 1, 0);
        idle(2, 0);
        step(0, 0, '0, '0, '0, 0, 0, 1);
        idle(3, 1);

        // Reset mid-flight after two issues, with nonzero sticky flags beforehand.
        step(1, 0, 5'd11, 32'h3f800000, 5'h08, 1, 0, 0);
        idle(5, 1);
        step(1, 0, 5'd12, 32'h40000000, 5'h01, 1, 0, 0);
        step(1, 0, 5'd13, 32'h40400000, 5'h02, 1, 0, 0);
        step(0, 0, '0, '0, '0, 1, 0, 1);
        idle(6, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fma_wb.md
# fma_wb

Writeback and exception-accumulation stage placed directly downstream of the single-precision fused multiply-add unit (`fmas`). It tracks each issued FMA by destination tag through the unit's fixed two-cycle pipeline and captures the result and flags when they appear. It buffers completed results in a small FIFO and drains them to the register file over a valid/ready handshake. It also ORs retired exception flags into a sticky `fflags` register and applies issue backpressure so the non-stallable FMA pipe can never overflow the buffer.

## Interface
Parameters:
- `DEPTH`, 4: result FIFO entries; power of two, 2..16.
- `TAG_W`, 5: destination-register tag width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `issue_valid`  in  1  FMA issued this cycle; wired to the same signal as `fmas.req`.
- `issue_tag`  in  TAG_W  destination tag of the issued op.
- `issue_ready`  out  1  issue permitted this cycle (credit available).
- `fmas_rslt`  in  32  `fmas.rslt` (combinational output).
- `fmas_flag`  in  5  `fmas.flag`: [4] NV, [3] DZ, [2] OF, [1] UF, [0] NX.
- `wb_valid`  out  1  FIFO head valid.
- `wb_ready`  in  1  register file accepts the head.
- `wb_tag`  out  TAG_W  head tag.
- `wb_data`  out  32  head result.
- `wb_flag`  out  5  head flags.
- `fflags_clr`  in  1  clear the sticky flags (CSR write).
- `fflags`  out  5  sticky accrued exception flags.
- `ovf_err`  out  1  sticky: issue seen while `issue_ready`=0.

## Operation
- **Tag pipe.** Two register stages, each holding a valid bit and a tag.
  - Stage A loads {`issue_valid`, `issue_tag`} every cycle.
  - Stage B loads stage A every cycle.
  - Stage B valid marks the cycle in which `fmas_rslt`/`fmas_flag` belong to that tag.
- **Capture.** When stage B is valid, push {B.tag, `fmas_rslt`, `fmas_flag`} into the FIFO.
  - A push is never refused; the credit logic guarantees space.
  - Push data is taken as-is, including NaN-path flags.
- **FIFO.** Write and read pointers of log2(DEPTH) bits, plus `count` of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - Outputs `wb_*` come straight from the head entry; `wb_valid` = (`count`≠0).
  - Pop when `wb_valid`&`wb_ready`.
  - Push and pop in the same cycle leave `count` unchanged, including at `count`=DEPTH.
- **Credit.** `inflight` = A.valid + B.valid (0..2).
  - `issue_ready` = (`count` + `inflight` − pop_this_cycle) < DEPTH, evaluated combinationally.
  - If `issue_valid`&~`issue_ready`, set `ovf_err` and still track the op. The capture then overwrites the oldest unread slot; this is a protocol violation, so contents are undefined but pointers stay consistent.
- **Sticky flags.** Flags accrue at retirement (pop), not at capture.
  - `fflags_next` = (`fflags_clr` ? 0 : `fflags`) | (pop ? `wb_flag` : 0).
  - When a clear and a pop occur in the same cycle, the popped flags survive.
- **Reset.** Applies mid-operation:
  - Clears tag-pipe valids, pointers, `count`, `fflags` and `ovf_err`.
  - In-flight and buffered results are discarded.
  - `fmas` resets its own enables in the same cycle, so no stale capture follows.

## Timing
- Reset values:
  - `issue_ready`=1.
  - `wb_valid`=0, `fflags`=0, `ovf_err`=0.
  - `wb_tag`/`wb_data`/`wb_flag` don't-care while `wb_valid`=0.
- Issue in cycle T → result valid at the `fmas` output in cycle T+2 → captured at the end of T+2 → `wb_valid`=1 in T+3 when the FIFO was empty.
- Issue-to-writeback latency is 3 cycles minimum.
- Throughput is one op per cycle, sustained while `wb_ready`=1.
- `fflags` updates in the cycle after the pop handshake.
- `issue_ready` depends combinationally on `wb_ready`, and `wb_ready` must not depend on `issue_ready`.

## Test plan
- **Single op.** Issue x=0x3f800000, y=0x40000000, z=0x3f800000, tag 7, `wb_ready`=1.
  - Expect `wb_valid` at T+3 with `wb_data`=0x40400000, `wb_flag`=0x00, `wb_tag`=7; `fflags` stays 0.
- **Signalling NaN.** Issue x=0x7f800001, tag 3.
  - Expect `wb_data`=0x7fc00001, `wb_flag`=0x10, then `fflags`=0x10 one cycle after the pop.
  - Pulse `fflags_clr` on the same cycle as a pop of flag 0x05 → `fflags`=0x05.
- **Backpressure.** Hold `wb_ready`=0 and issue back-to-back on tags 1,2,3,….
  - `issue_ready` drops after exactly DEPTH issues (4 with the default DEPTH).
  - No `ovf_err`; all 4 entries drain in order 1..4 once `wb_ready`=1.
- **Full with simultaneous push/pop.** With `count`=4, B valid and `wb_ready`=1 in the same cycle: `count` stays 4, order is preserved, and 8+ ops drain in issue order across pointer wrap.
- **Overflow error.** Force `issue_valid` while `issue_ready`=0 → `ovf_err`=1 next cycle and stays set until reset.
- **Reset mid-flight.** Reset asserted one cycle after issuing 2 ops → no `wb_valid` afterwards, `issue_ready`=1, and `fflags`=0.
